morse_keyer: RTL

//  Morse symbol transmitter. Accepts symbol codes (dot/dash/space) over a valid/ready

---
 rtl/morse_keyer_if.sv | 12 +
 rtl/morse_keyer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/morse_keyer_if.sv
// Symbol handshake between an upstream symbol source and the Morse keyer.
// A symbol moves on any posedge where sym_valid and sym_ready are both high.
// The source holds sym stable while sym_valid is high. It may drop sym_valid
// without a transfer. sym_ready depends only on keyer state, never on sym_valid.
interface morse_keyer_if;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sym_ready;

   modport master (output sym_valid, output sym, input sym_ready);
   modport slave  (input sym_valid, input sym, output sym_ready);
endinterface

// File: rtl/morse_keyer.sv
// Morse symbol transmitter. Symbol codes: 00 dot, 11 dash, 10 space, 01 reserved.
// Accepted symbols are buffered in a small FIFO and keyed onto line_out.
// Each dot or dash is a mark followed by a gap. A space is low time only.
module morse_keyer #(
   parameter int UNIT_CYCLES = 1,
   parameter int DASH_UNITS  = 3,
   parameter int GAP_UNITS   = 1,
   parameter int SPACE_UNITS = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   morse_keyer_if.slave     bus,
   output logic             line_out,
   output logic             sym_done,
   output logic             err_sym,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int DOT_LEN   = UNIT_CYCLES;
   localparam int DASH_LEN  = DASH_UNITS * UNIT_CYCLES;
   localparam int GAP_LEN   = GAP_UNITS * UNIT_CYCLES;
   localparam int SPACE_LEN = SPACE_UNITS * UNIT_CYCLES;
   localparam int MAX_DS    = (DASH_LEN > SPACE_LEN) ? DASH_LEN : SPACE_LEN;
   localparam int MAX_LEN   = (MAX_DS > GAP_LEN) ? MAX_DS : GAP_LEN;
   localparam int CW        = $clog2(MAX_LEN + 1);

   // The counter is loaded with length-1 and counts down to 0.
   localparam logic [CW-1:0] DOT_LOAD   = CW'(DOT_LEN - 1);
   localparam logic [CW-1:0] DASH_LOAD  = CW'(DASH_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);
   localparam logic [CW-1:0] SPACE_LOAD = CW'(SPACE_LEN - 1);
   localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, MARK, GAP, SPACE} state_t;

   state_t          state, state_nxt, load_state;
   logic [CW-1:0]   cnt, cnt_nxt, load_cnt;
   logic [1:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            accept, push, pop, fifo_empty;
   logic [1:0]      head;

   // sym_ready uses only the registered count, so a pop on a full FIFO does not
   // open the input in the same cycle.
   assign bus.sym_ready = (count != CNT_FULL);
   assign accept        = bus.sym_valid & bus.sym_ready;
   assign push          = accept & (bus.sym != 2'b01);
   assign fifo_empty    = (count == '0);
   assign head          = mem[rd_ptr];
   assign busy          = (state != IDLE) | ~fifo_empty;
   assign state_dbg     = state;

   // FIFO storage. It needs no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.sym;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Decode the FIFO head into the state and counter load used when it is popped.
   always_comb begin
      load_state = MARK;
      load_cnt   = DOT_LOAD;
      if (head == 2'b10) begin
         load_state = SPACE;
         load_cnt   = SPACE_LOAD;
      end else if (head == 2'b11) begin
         load_cnt   = DASH_LOAD;
      end
   end

   // Next-state logic. The final cycle of a gap or space pops the next symbol
   // directly, so consecutive symbols have no idle cycle between them.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      sym_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = load_state;
               cnt_nxt   = load_cnt;
            end
         end
         MARK: begin
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt   = cnt - CW'(1);
            end
         end
         GAP, SPACE: begin
            if (cnt == '0) begin
               sym_done = 1'b1;
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = load_state;
                  cnt_nxt   = load_cnt;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter, the registered key line and the reserved-code flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         line_out <= 1'b0;
         err_sym  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         line_out <= (state_nxt == MARK);
         err_sym  <= accept & (bus.sym == 2'b01);
      end
   end

endmodule
